// File: rtl/io_bank_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : io_bank_pkg
// Description : Shared constants and elaboration helpers for the IO lane bank.
// Revision    : 1.0 - initial release
// ============================================================================
package io_bank_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILTER_LEN_DEF  = 4;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int FILTER_LEN_MIN  = 1;
    localparam int FILTER_LEN_MAX  = 255;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // A filter of length 1 still needs a one-bit counter to keep vectors legal.
    function automatic int cnt_width(input int filter_len);
        return (clog2(filter_len) < 1) ? 1 : clog2(filter_len);
    endfunction

    function automatic bit sync_stages_legal(input int n);
        return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
    endfunction

    function automatic bit filter_len_legal(input int n);
        return (n >= FILTER_LEN_MIN) && (n <= FILTER_LEN_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_in_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : io_in_filter
// Description : One input lane: synchroniser, glitch filter, din and edge pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module io_in_filter
    import io_bank_pkg::*;
#(
    parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int   FILTER_LEN  = FILTER_LEN_DEF,
    parameter logic IN_RST      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic hold,
    input  logic pad_i,
    output logic din,
    output logic din_rise,
    output logic din_fall
);

    localparam int                c_cnt_w   = cnt_width(FILTER_LEN);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(FILTER_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_din;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_s;
    logic                   w_update;

    // Free-running so metastability settling is never stalled by ce or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{IN_RST}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pad_i};
        end
    end

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_update = ce && !hold && (w_s != r_din) && (r_cnt == c_cnt_max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_din  <= IN_RST;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_update &  w_s;
            r_fall <= w_update & ~w_s;
            if (hold) begin
                r_cnt <= '0;
            end else if (ce) begin
                if (w_s == r_din) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_max) begin
                    r_din <= w_s;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end
        end
    end

    assign din      = r_din;
    assign din_rise = r_rise;
    assign din_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/io_lane_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : io_lane_bank
// Description : Multi-lane pad interface: output/enable registers plus filtered inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module io_lane_bank
    import io_bank_pkg::*;
#(
    parameter int               LANES       = 8,
    parameter int               SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int               FILTER_LEN  = FILTER_LEN_DEF,
    parameter int               OUT_REG     = 1,
    parameter logic [LANES-1:0] OUT_RST     = {LANES{1'b0}},
    parameter logic [LANES-1:0] IN_RST      = {LANES{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             hold,
    input  logic [LANES-1:0] dout,
    input  logic [LANES-1:0] oe,
    output logic [LANES-1:0] pad_o,
    output logic [LANES-1:0] pad_oe,
    input  logic [LANES-1:0] pad_i,
    output logic [LANES-1:0] din,
    output logic [LANES-1:0] din_rise,
    output logic [LANES-1:0] din_fall
);

    if (!sync_stages_legal(SYNC_STAGES)) begin : g_chk_sync
        $error("io_lane_bank: SYNC_STAGES must be in 2..4");
    end

    if (!filter_len_legal(FILTER_LEN)) begin : g_chk_filter
        $error("io_lane_bank: FILTER_LEN must be in 1..255");
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [LANES-1:0] r_pad_o;
        logic [LANES-1:0] r_pad_oe;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_pad_o  <= OUT_RST;
                r_pad_oe <= '0;
            end else if (ce) begin
                r_pad_o  <= dout;
                r_pad_oe <= oe;
            end
        end

        assign pad_o  = r_pad_o;
        assign pad_oe = r_pad_oe;
    end else begin : g_out_comb
        // Pads must stay high-Z during reset even without an output register.
        assign pad_o  = dout;
        assign pad_oe = oe & ~{LANES{rst}};
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        io_in_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN),
            .IN_RST      (IN_RST[i])
        ) u_in_filter (
            .clk      (clk),
            .rst      (rst),
            .ce       (ce),
            .hold     (hold),
            .pad_i    (pad_i[i]),
            .din      (din[i]),
            .din_rise (din_rise[i]),
            .din_fall (din_fall[i])
        );
    end

endmodule
`default_nettype wire
